// File: rtl/branch_target_buffer_pkg.sv
// branch_target_buffer_pkg -- FetchUnitTypes BTB encodings, entry layout and FSM states (rev 1.0)
`default_nettype none

package branch_target_buffer_pkg;

  localparam int BTB_ENTRY_NUM         = 1024;
  localparam int INST_ALLIGN           = 2;
  localparam int BTB_INDEX_WIDTH       = $clog2(BTB_ENTRY_NUM);
  localparam int BTB_CONTENTS_WIDTH    = 13;
  localparam int BTB_TAG_WIDTH         = 32 - INST_ALLIGN - BTB_INDEX_WIDTH;
  localparam int BTB_TARGET_WINDOW_LSB = BTB_CONTENTS_WIDTH + INST_ALLIGN;

  typedef logic [BTB_INDEX_WIDTH-1:0]    BTBIndexPath;
  typedef logic [BTB_TAG_WIDTH-1:0]      BTBTag;
  typedef logic [BTB_CONTENTS_WIDTH-1:0] BTBContent;

  typedef struct packed {
    BTBTag     tag;
    BTBContent data;
  } BTBEntry;

  typedef struct packed {
    logic    valid;
    BTBEntry entry;
  } BTBValidEntry;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } BTBState;

  function automatic BTBIndexPath ToBTB_Index(input logic [31:0] pc);
    return pc[INST_ALLIGN +: BTB_INDEX_WIDTH];
  endfunction

  function automatic BTBTag ToBTB_Tag(input logic [31:0] pc);
    return pc[31 -: BTB_TAG_WIDTH];
  endfunction

  function automatic BTBContent ToBTB_Content(input logic [31:0] target);
    return target[INST_ALLIGN +: BTB_CONTENTS_WIDTH];
  endfunction

  function automatic logic [31:0] ToRawAddrFromBTB_PC(input BTBContent content, input logic [31:0] pc);
    return {pc[31:BTB_TARGET_WINDOW_LSB], content, {INST_ALLIGN{1'b0}}};
  endfunction

  // Only targets that share the branch's upper PC bits and are word aligned fit in an entry.
  function automatic logic InTargetWindow(input logic [31:0] target, input logic [31:0] pc);
    return (target[31:BTB_TARGET_WINDOW_LSB] == pc[31:BTB_TARGET_WINDOW_LSB]) &&
           (target[INST_ALLIGN-1:0] == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_target_buffer_storage.sv
// btb_storage -- synchronous-read, single-write-port RAM of BTB entries (rev 1.0)
// BTB_BYPASS_EN selects write-first forwarding; otherwise read-first simple dual-port.
`default_nettype none

module btb_storage
  import branch_target_buffer_pkg::*;
#(
  parameter int DEPTH = BTB_ENTRY_NUM,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  BTBValidEntry    wdata_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  output BTBValidEntry    rdata_o
);

  BTBValidEntry mem_q [DEPTH];
  BTBValidEntry rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

`ifdef BTB_BYPASS_EN
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end
`endif

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/branch_target_buffer.sv
// branch_target_buffer -- direct-mapped BTB with a post-reset valid-bit sweep (rev 1.0)
// Optional BTB_BYPASS_EN: same-cycle lookup of a just-written index sees the new entry.
`default_nettype none

module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRY_NUM = BTB_ENTRY_NUM
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        lookup_en,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic        init_done
);

  localparam int IDX_W = $clog2(ENTRY_NUM);
  typedef logic [IDX_W-1:0] idx_t;

  BTBState      state_q, state_d;
  idx_t         clr_cnt_q, clr_cnt_d;
  logic         lk_valid_q;
  logic [31:0]  lk_pc_q;

  logic         ram_we, ram_re;
  idx_t         ram_waddr, ram_raddr;
  BTBValidEntry ram_wdata, ram_rdata;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q    <= INIT;
      clr_cnt_q  <= '0;
      lk_valid_q <= 1'b0;
      lk_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      lk_valid_q <= ram_re;
      if (ram_re) begin
        lk_pc_q <= lookup_pc;
      end
    end
  end

  // The sweep borrows the single write port, so updates wait until READY.
  always_comb begin
    state_d               = state_q;
    clr_cnt_d             = clr_cnt_q;
    upd_ready             = 1'b0;
    init_done             = 1'b0;
    ram_we                = 1'b0;
    ram_waddr             = idx_t'(ToBTB_Index(upd_pc));
    ram_wdata.valid       = 1'b1;
    ram_wdata.entry.tag   = ToBTB_Tag(upd_pc);
    ram_wdata.entry.data  = ToBTB_Content(upd_target);
    case (state_q)
      INIT: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        ram_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == idx_t'(ENTRY_NUM - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        upd_ready = 1'b1;
        init_done = 1'b1;
        ram_we    = upd_valid && upd_taken && InTargetWindow(upd_target, upd_pc);
      end
      default: state_d = INIT;
    endcase
  end

  assign ram_re    = lookup_en && (state_q == READY);
  assign ram_raddr = idx_t'(ToBTB_Index(lookup_pc));

  btb_storage #(
    .DEPTH (ENTRY_NUM),
    .AW    (IDX_W)
  ) u_storage (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign pred_hit    = lk_valid_q && ram_rdata.valid && (ram_rdata.entry.tag == ToBTB_Tag(lk_pc_q));
  assign pred_target = pred_hit ? ToRawAddrFromBTB_PC(ram_rdata.entry.data, lk_pc_q) : 32'h0;

endmodule

`default_nettype wire

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped 1024-entry branch target buffer in the fetch unit. The execute stage writes resolved taken branches into it, and the fetch stage reads it to predict the next PC. Each entry is packed with the FetchUnitTypes index, tag and content encoding, and the read side reconstructs the full 32-bit target from the stored content. After every reset, an internal sequencer clears all valid bits before the buffer accepts traffic.

## Interface
Parameters:
- `ENTRY_NUM`, default `BTB_ENTRY_NUM` (1024): number of entries; must be a power of two.

Ports:
- `clk` in 1: single clock.
- `rstN` in 1: reset, synchronous, active-low.
- `lookup_en` in 1: fetch issues a lookup this cycle.
- `lookup_pc` in 32: fetch PC to look up.
- `pred_hit` out 1: the previous cycle's lookup hit.
- `pred_target` out 32: predicted target; 0 when `pred_hit`=0.
- `upd_valid` in 1: execute presents a resolved branch.
- `upd_ready` out 1: the update is accepted this cycle.
- `upd_pc` in 32: branch instruction PC.
- `upd_target` in 32: resolved target.
- `upd_taken` in 1: branch was taken.
- `init_done` out 1: clearing is finished and the buffer is operational.

## Operation
- Storage: `ENTRY_NUM` × {valid, `BTBTag`, `BTBContent`}.
  - Index = `ToBTB_Index(pc)`, tag = `ToBTB_Tag(pc)`, content = `ToBTB_Content(target)`.
- FSM states: `INIT` and `READY`.
  - `rstN`=0 → `INIT`, clear counter = 0.
  - In `INIT`, one valid bit is cleared per cycle at index = counter; the counter increments.
  - When counter = `ENTRY_NUM-1` is cleared → `READY`.
  - Reset asserted in any state restarts at `INIT` with counter 0.
- In `INIT`:
  - `upd_ready`=0, `init_done`=0.
  - Lookups are ignored; `pred_hit`=0.
- In `READY`:
  - `upd_ready`=1 and `init_done`=1.
  - An update handshake is `upd_valid` && `upd_ready`.
- Update write rule: write {1, tag(`upd_pc`), content(`upd_target`)} at index(`upd_pc`) only if all of the following hold:
  - `upd_taken`=1;
  - `upd_target[31:15]` == `upd_pc[31:15]` (a target outside the representable window is not written);
  - `upd_target[1:0]` == 0.
- Otherwise an accepted update is dropped with no state change. Not-taken updates never invalidate an entry.
- Lookup rule:
  - `lookup_en` registers `lookup_pc` and reads the entry at its index.
  - Hit = stored valid && stored tag == `ToBTB_Tag(registered pc)`.
  - On a hit, `pred_target` = `ToRawAddrFromBTB_PC(stored content, registered pc)`, i.e. {pc[31:15], content, 2'b0}.
- Same-cycle lookup and write to the same index: the behaviour depends on `BTB_BYPASS_EN` (see Configuration).
- Same-cycle lookup and write to different indices: both take effect independently.

## Timing
- Reset values: `pred_hit`=0, `pred_target`=0, `upd_ready`=0, `init_done`=0, all valid bits treated as 0 from the first post-reset cycle.
- `init_done` rises exactly `ENTRY_NUM` cycles after the first cycle with `rstN`=1.
- Lookup latency is 1 cycle: a lookup presented in cycle N produces `pred_hit`/`pred_target` in N+1.
  - `lookup_en`=0 in cycle N gives `pred_hit`=0 and `pred_target`=0 in N+1.
- A write accepted in cycle N is visible to lookups issued in cycle N+1 and later.
- Updates are accepted in the same cycle `upd_valid` is seen, with no backpressure in `READY`.

## Configuration
- `BTB_BYPASS_EN` defined: a same-cycle lookup and write to the same index returns the newly written entry in N+1 (write-first forwarding).
- `BTB_BYPASS_EN` undefined: the same case returns the old entry (read-first). Storage maps to a simple dual-port BRAM with no forwarding mux.

## Structure
- Add to the FetchUnitTypes package:
  - `BTBValidEntry` struct {valid, `BTBEntry`};
  - `BTBState` enum {`INIT`, `READY`};
  - `BTB_TARGET_WINDOW_LSB` = `BTB_CONTENTS_WIDTH`+`INST_ALLIGN` (15).
- Sub-module `btb_storage`: a synchronous read, single write-port RAM of `BTBValidEntry` with the optional forwarding path. The FSM, clear counter and hit logic live in the top module.

## Test plan
- Reset release, then hold `upd_valid`=1 → `upd_ready`=0 for 1024 cycles; `init_done`=1 on cycle 1024; no writes occur.
- Update pc=0x0000_1000, target=0x0000_1F00, taken; then lookup 0x0000_1000 → `pred_hit`=1, `pred_target`=0x0000_1F00 one cycle later.
- Lookup 0x0001_1000 (same index, different tag) → `pred_hit`=0, `pred_target`=0.
- Update pc=0x0000_2000, target=0x0001_0000, taken (outside the window) → next lookup of 0x0000_2000 misses. A not-taken update to an existing entry leaves it hitting.
- Same-cycle write and lookup of pc=0x0000_3000 → miss without `BTB_BYPASS_EN`; hit with target with it.
- Assert `rstN`=0 for 1 cycle mid-operation → `init_done`=0 and a re-sweep of 1024 cycles; the previously written 0x0000_1000 then misses.
